// File: rtl/gnn_layer_seq.sv
// gnn_layer_seq: a single graph-convolution layer that shares one multiplier
// over time. It captures X, W and the adjacency mask, computes H = X*W one MAC
// per cycle, then sums each node's neighbours' H rows, plus the node's own row
// when SELF_LOOP is set, into Y at one add per cycle.
module gnn_layer_seq #(
    parameter int N_NODES   = 4,
    parameter int F_IN      = 4,
    parameter int F_OUT     = 4,
    parameter int DW        = 5,
    parameter int OW        = 21,
    parameter bit SELF_LOOP = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_ready,
    input  logic [N_NODES*F_IN*DW-1:0]    x_flat,
    input  logic [F_IN*F_OUT*DW-1:0]      w_flat,
    input  logic [N_NODES*N_NODES-1:0]    adj,
    output logic                          busy,
    output logic                          out_ready,
    output logic [N_NODES*F_OUT*OW-1:0]   y_flat
);

    // An H element holds a sum of F_IN products, so it cannot overflow.
    localparam int HW  = 2*DW + $clog2(F_IN);
    // This is the working width used to sign-extend H before it is cut to OW.
    localparam int EW  = (OW > HW) ? OW : HW;
    localparam int NCW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int ICW = (F_IN    > 1) ? $clog2(F_IN)    : 1;
    localparam int OCW = (F_OUT   > 1) ? $clog2(F_OUT)   : 1;

    localparam logic [NCW-1:0] N_LAST = NCW'(N_NODES - 1);
    localparam logic [ICW-1:0] I_LAST = ICW'(F_IN - 1);
    localparam logic [OCW-1:0] O_LAST = OCW'(F_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFORM,
        S_AGG,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   out_ready_q;

    // Operands captured at the start of a run.
    logic signed [DW-1:0]   x_q   [N_NODES][F_IN];
    logic signed [DW-1:0]   w_q   [F_IN][F_OUT];
    logic                   adj_q [N_NODES][N_NODES];

    // Intermediate H, the results, and the running aggregate.
    logic signed [HW-1:0]   h_q   [N_NODES][F_OUT];
    logic [OW-1:0]          y_q   [N_NODES][F_OUT];
    logic [OW-1:0]          acc_q;

    // Loop counters. XFORM walks n, o, i. AGG walks n, o, m.
    logic [NCW-1:0]         n_q;
    logic [OCW-1:0]         o_q;
    logic [ICW-1:0]         i_q;
    logic [NCW-1:0]         m_q;

    // Combinational datapath values.
    logic signed [2*DW-1:0] prod_d;
    logic signed [HW-1:0]   mac_d;
    logic signed [EW-1:0]   h_wide_d;
    logic                   include_d;
    logic [OW-1:0]          term_d;
    logic [OW-1:0]          sum_d;

    // Shared datapath: one signed MAC for XFORM and one modular add for AGG.
    // NOTE: every always_comb output gets a default assignment before any
    // branch, so a path that is not covered cannot infer a latch.
    always_comb begin
        prod_d    = '0;
        mac_d     = '0;
        h_wide_d  = '0;
        include_d = 1'b0;
        term_d    = '0;
        sum_d     = '0;

        prod_d    = (2*DW)'(x_q[n_q][i_q]) * (2*DW)'(w_q[i_q][o_q]);
        mac_d     = h_q[n_q][o_q] + HW'(prod_d);

        // When the adjacency self bit and SELF_LOOP are both set, the OR
        // makes the node's own row count once, not twice.
        include_d = adj_q[n_q][m_q] || (SELF_LOOP && (m_q == n_q));
        h_wide_d  = EW'(h_q[m_q][o_q]);
        term_d    = include_d ? h_wide_d[OW-1:0] : '0;
        sum_d     = ((m_q == '0) ? '0 : acc_q) + term_d;
    end

    // Capture the operands when a run starts. The values are held until the next start.
    // NOTE: these operand arrays have no reset. Each run writes them before
    // reading them, so a reset would only add flops to the reset net.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && in_ready) begin
            for (int n = 0; n < N_NODES; n++) begin
                for (int i = 0; i < F_IN; i++) begin
                    x_q[n][i] <= x_flat[(n*F_IN + i)*DW +: DW];
                end
                for (int m = 0; m < N_NODES; m++) begin
                    adj_q[n][m] <= adj[n*N_NODES + m];
                end
            end
            for (int i = 0; i < F_IN; i++) begin
                for (int o = 0; o < F_OUT; o++) begin
                    w_q[i][o] <= w_flat[(i*F_OUT + o)*DW +: DW];
                end
            end
        end
    end

    // Control FSM, loop counters, H/Y accumulation and registered status outputs.
    // NOTE: all state here uses non-blocking assignments. Every register then
    // sees values from before the edge, whatever order the statements run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_ready_q <= 1'b0;
            acc_q       <= '0;
            n_q         <= '0;
            o_q         <= '0;
            i_q         <= '0;
            m_q         <= '0;
            for (int n = 0; n < N_NODES; n++) begin
                for (int o = 0; o < F_OUT; o++) begin
                    h_q[n][o] <= '0;
                    y_q[n][o] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_ready) begin
                        for (int n = 0; n < N_NODES; n++) begin
                            for (int o = 0; o < F_OUT; o++) begin
                                h_q[n][o] <= '0;
                            end
                        end
                        n_q     <= '0;
                        o_q     <= '0;
                        i_q     <= '0;
                        m_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_XFORM;
                    end
                end

                S_XFORM: begin
                    h_q[n_q][o_q] <= mac_d;
                    if (i_q == I_LAST) begin
                        i_q <= '0;
                        if (o_q == O_LAST) begin
                            o_q <= '0;
                            if (n_q == N_LAST) begin
                                n_q     <= '0;
                                state_q <= S_AGG;
                            end else begin
                                n_q <= n_q + NCW'(1);
                            end
                        end else begin
                            o_q <= o_q + OCW'(1);
                        end
                    end else begin
                        i_q <= i_q + ICW'(1);
                    end
                end

                S_AGG: begin
                    if (m_q == N_LAST) begin
                        y_q[n_q][o_q] <= sum_d;
                        acc_q         <= '0;
                        m_q           <= '0;
                        if (o_q == O_LAST) begin
                            o_q <= '0;
                            if (n_q == N_LAST) begin
                                n_q         <= '0;
                                busy_q      <= 1'b0;
                                out_ready_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                n_q <= n_q + NCW'(1);
                            end
                        end else begin
                            o_q <= o_q + OCW'(1);
                        end
                    end else begin
                        acc_q <= sum_d;
                        m_q   <= m_q + NCW'(1);
                    end
                end

                S_DONE: begin
                    // A new run needs in_ready to go low first, so holding it
                    // high here keeps the block in DONE.
                    if (!in_ready) begin
                        out_ready_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    busy_q      <= 1'b0;
                    out_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Flatten the result registers onto the output bus.
    always_comb begin
        y_flat = '0;
        for (int n = 0; n < N_NODES; n++) begin
            for (int o = 0; o < F_OUT; o++) begin
                y_flat[(n*F_OUT + o)*OW +: OW] = y_q[n][o];
            end
        end
    end

    assign busy      = busy_q;
    assign out_ready = out_ready_q;

endmodule

// File: tb/tb_gnn_layer_seq.sv
// Testbench for gnn_layer_seq. A driver starts runs and pushes the result
// expected from a reference model. A separate monitor pops that result when
// out_ready rises and compares it and the latency.
module tb_gnn_layer_seq;

    localparam int N_NODES   = 4;
    localparam int F_IN      = 4;
    localparam int F_OUT     = 4;
    localparam int DW        = 5;
    localparam int OW        = 21;
    localparam bit SELF_LOOP = 1'b1;

    localparam int XW  = N_NODES*F_IN*DW;
    localparam int WW  = F_IN*F_OUT*DW;
    localparam int AW  = N_NODES*N_NODES;
    localparam int YW  = N_NODES*F_OUT*OW;
    localparam int LAT = N_NODES*F_OUT*(F_IN + N_NODES);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_ready;
    logic [XW-1:0] x_flat;
    logic [WW-1:0] w_flat;
    logic [AW-1:0] adj;
    logic          busy;
    logic          out_ready;
    logic [YW-1:0] y_flat;

    typedef struct {
        logic [YW-1:0] y;
        int            cap;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [YW-1:0] cur_y;
    logic [YW-1:0] kept_y;

    gnn_layer_seq #(
        .N_NODES  (N_NODES),
        .F_IN     (F_IN),
        .F_OUT    (F_OUT),
        .DW       (DW),
        .OW       (OW),
        .SELF_LOOP(SELF_LOOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_ready (in_ready),
        .x_flat   (x_flat),
        .w_flat   (w_flat),
        .adj      (adj),
        .busy     (busy),
        .out_ready(out_ready),
        .y_flat   (y_flat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_y(input string name, input logic [YW-1:0] exp);
        logic signed [OW-1:0] a;
        logic signed [OW-1:0] e;
        for (int n = 0; n < N_NODES; n++) begin
            for (int o = 0; o < F_OUT; o++) begin
                a = y_flat[(n*F_OUT + o)*OW +: OW];
                e = exp[(n*F_OUT + o)*OW +: OW];
                check($sformatf("%s y(%0d,%0d)", name, n, o), a, e);
            end
        end
    endtask

    // The reference model works from the mathematical definition: H = X*W, and
    // Y[n] is the sum of H[m] over the selected m, kept modulo 2^OW.
    function automatic logic [YW-1:0] model(input logic [XW-1:0] x,
                                            input logic [WW-1:0] w,
                                            input logic [AW-1:0] a);
        longint               h [N_NODES][F_OUT];
        logic signed [DW-1:0] xe;
        logic signed [DW-1:0] we;
        longint               s;
        logic [YW-1:0]        y;
        y = '0;
        for (int n = 0; n < N_NODES; n++) begin
            for (int o = 0; o < F_OUT; o++) begin
                h[n][o] = 0;
                for (int i = 0; i < F_IN; i++) begin
                    xe = x[(n*F_IN + i)*DW +: DW];
                    we = w[(i*F_OUT + o)*DW +: DW];
                    h[n][o] += longint'(xe) * longint'(we);
                end
            end
        end
        for (int n = 0; n < N_NODES; n++) begin
            for (int o = 0; o < F_OUT; o++) begin
                s = 0;
                for (int m = 0; m < N_NODES; m++) begin
                    if (a[n*N_NODES + m] || (SELF_LOOP && m == n)) s += h[m][o];
                end
                y[(n*F_OUT + o)*OW +: OW] = s[OW-1:0];
            end
        end
        return y;
    endfunction

    function automatic logic [XW-1:0] fill_x(input int v);
        logic [XW-1:0] r;
        for (int k = 0; k < N_NODES*F_IN; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [WW-1:0] fill_w(input int v);
        logic [WW-1:0] r;
        for (int k = 0; k < F_IN*F_OUT; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [AW-1:0] ring_adj();
        logic [AW-1:0] r;
        r = '0;
        for (int n = 0; n < N_NODES; n++) begin
            r[n*N_NODES + (n + 1) % N_NODES]           = 1'b1;
            r[n*N_NODES + (n + N_NODES - 1) % N_NODES] = 1'b1;
        end
        return r;
    endfunction

    task automatic randomize_inputs();
        for (int k = 0; k < XW; k++) x_flat[k] = 1'($urandom_range(0, 1));
        for (int k = 0; k < WW; k++) w_flat[k] = 1'($urandom_range(0, 1));
        for (int k = 0; k < AW; k++) adj[k]    = 1'($urandom_range(0, 1));
    endtask

    // Call this at a negedge while the DUT is in IDLE. The next edge captures.
    task automatic start_run(input logic [XW-1:0] x, input logic [WW-1:0] w,
                             input logic [AW-1:0] a);
        exp_t e;
        x_flat   = x;
        w_flat   = w;
        adj      = a;
        in_ready = 1'b1;
        cur_y    = model(x, w, a);
        e.y      = cur_y;
        e.cap    = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_ready = 1'b0;
        check("busy after capture", busy, 1);
        check("out_ready after capture", out_ready, 0);
        check_y("y kept in XFORM", kept_y);
    endtask

    // Wait, with a bound, for out_ready. The inputs are scrambled meanwhile to show they are ignored.
    task automatic wait_done();
        int k;
        k = 0;
        while (out_ready !== 1'b1 && k < LAT + 20) begin
            @(negedge clk);
            randomize_inputs();
            k++;
        end
        if (out_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_ready=%b after %0d cycles", out_ready, k);
        end
        kept_y = cur_y;
    endtask

    task automatic run(input logic [XW-1:0] x, input logic [WW-1:0] w,
                       input logic [AW-1:0] a);
        start_run(x, w, a);
        wait_done();
        @(negedge clk);
        check("out_ready back in IDLE", out_ready, 0);
    endtask

    // The monitor compares the scoreboard head each time out_ready rises. It also checks that busy and out_ready are never high together.
    initial begin
        logic prev_or;
        exp_t e;
        prev_or = 1'b0;
        forever begin
            @(negedge clk);
            check("busy&out_ready exclusive", busy & out_ready, 0);
            if (out_ready === 1'b1 && prev_or !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected out_ready: got 1 expected no pending run");
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.cap, LAT);
                    check_y("result", e.y);
                end
            end
            prev_or = out_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XW-1:0] xo;
        logic [WW-1:0] wo;
        rst      = 1'b1;
        in_ready = 1'b0;
        x_flat   = '0;
        w_flat   = '0;
        adj      = '0;
        kept_y   = '0;
        cur_y    = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset out_ready", out_ready, 0);
        check_y("reset", '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases on the ring graph.
        run(fill_x(15), fill_w(15), ring_adj());
        run(fill_x(-16), fill_w(-16), ring_adj());
        run(fill_x(15), fill_w(-16), ring_adj());

        // Only x[n][0] and w[0][0] are nonzero, so each output can be traced to its source nodes.
        xo = '0;
        wo = '0;
        for (int n = 0; n < N_NODES; n++) xo[(n*F_IN)*DW +: DW] = DW'(n + 1);
        wo[0 +: DW] = DW'(1);
        run(xo, wo, ring_adj());

        // Self loop only, then full adjacency with the diagonal set (self counted once).
        run(fill_x(15), fill_w(15), '0);
        run(fill_x(15), fill_w(15), '1);

        // Random operands and graphs.
        for (int r = 0; r < 4; r++) begin
            randomize_inputs();
            run(x_flat, w_flat, adj);
        end

        // Abort mid-run with rst, then run again from a clean start.
        randomize_inputs();
        start_run(x_flat, w_flat, adj);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst abort busy", busy, 0);
        check("rst abort out_ready", out_ready, 0);
        check_y("rst abort", '0);
        sb.delete();
        kept_y = '0;
        rst    = 1'b0;
        randomize_inputs();
        run(x_flat, w_flat, adj);

        // Hold in_ready high in DONE. The block must not restart, and it starts again only after a low cycle.
        randomize_inputs();
        start_run(x_flat, w_flat, adj);
        wait_done();
        in_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold out_ready", out_ready, 1);
            check("hold busy", busy, 0);
        end
        check_y("hold", cur_y);
        in_ready = 1'b0;
        @(negedge clk);
        check("out_ready after in_ready low", out_ready, 0);
        randomize_inputs();
        start_run(x_flat, w_flat, adj);
        wait_done();
        in_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
